regfile_sb: RTL and testbench

Register file with two combinational read ports, one write port and a pending-write scoreboard. It is the read/consume end of the write-number path: it receives the final destination number `wn`, which is already forced to 31 for `jal`, along with the writeback data. It serves operands to decode and raises `stall` when an operand or destination still has an outstanding producer. It sits between decode (read/issue side) and writeback (write side) of the MIPS pipeline.

---
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 32 x WIDTH register file with two combinational read ports,
// one write port and a pending-write scoreboard that drives issue stalls.
// Optional same-cycle writeback bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  input  logic             use_a,
  input  logic             use_b,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             qa_rdy,
  output logic             qb_rdy,
  input  logic             iss_valid,
  input  logic             iss_we,
  input  logic [4:0]       iss_wn,
  output logic             stall,
  input  logic             we,
  input  logic [4:0]       wn,
  input  logic [WIDTH-1:0] d,
  output logic [5:0]       busy_cnt
);

  logic [WIDTH-1:0] regs_q [32];
  logic [31:0]      busy_q, busy_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             wr_v, set_v, iss_ok, waw, inc, dec;
  logic             byp_a, byp_b;

  // Read ports: stored data, optionally overridden by the in-flight writeback
  always_comb begin
    wr_v = we & (wn != 5'd0);
`ifdef REGFILE_BYPASS_EN
    byp_a = wr_v & (wn == rna);
    byp_b = wr_v & (wn == rnb);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
    qa     = (rna == 5'd0) ? '0 : (byp_a ? d : regs_q[rna]);
    qb     = (rnb == 5'd0) ? '0 : (byp_b ? d : regs_q[rnb]);
    qa_rdy = (rna == 5'd0) | ~busy_q[rna] | byp_a;
    qb_rdy = (rnb == 5'd0) | ~busy_q[rnb] | byp_b;
  end

  // Issue hazard check: RAW on used operands, WAW on a busy destination
  always_comb begin
    waw    = iss_we & (iss_wn != 5'd0) & busy_q[iss_wn] & ~(we & (wn == iss_wn));
    stall  = iss_valid & ((use_a & ~qa_rdy) | (use_b & ~qb_rdy) | waw);
    iss_ok = iss_valid & ~stall;
    set_v  = iss_ok & iss_we & (iss_wn != 5'd0);
  end

  // Scoreboard next state: clear on writeback, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (wr_v) busy_d[wn] = 1'b0;
    if (set_v) busy_d[iss_wn] = 1'b1;
    busy_d[0] = 1'b0;
    // Count follows busy transitions only; a set+clear on one busy reg nets zero
    inc   = set_v & ~busy_q[iss_wn];
    dec   = wr_v & busy_q[wn] & ~(set_v & (iss_wn == wn));
    cnt_d = cnt_q + {5'd0, inc} - {5'd0, dec};
  end

  // Register storage; entry 0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_v) begin
      regs_q[wn] <= d;
    end
  end

  // Scoreboard bits and busy population count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test-plan scenarios plus randomized traffic checked
// against an array-based behavioural model of the register file/scoreboard.
module tb_regfile_sb;

  logic        clk, rst;
  logic [4:0]  rna, rnb, iss_wn, wn;
  logic        use_a, use_b, iss_valid, iss_we, we;
  logic [31:0] qa, qb, d;
  logic        qa_rdy, qb_rdy, stall;
  logic [5:0]  busy_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .use_a(use_a), .use_b(use_b),
    .qa(qa), .qb(qb), .qa_rdy(qa_rdy), .qb_rdy(qb_rdy), .iss_valid(iss_valid),
    .iss_we(iss_we), .iss_wn(iss_wn), .stall(stall), .we(we), .wn(wn), .d(d),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic bit wb_hits(input logic [4:0] rn);
    return BYP && we && (wn != 0) && (wn == rn);
  endfunction

  function automatic logic [31:0] exp_q(input logic [4:0] rn);
    if (rn == 0) return '0;
    if (wb_hits(rn)) return d;
    return mreg[rn];
  endfunction

  function automatic bit exp_rdy(input logic [4:0] rn);
    return (rn == 0) || !mbusy[rn] || wb_hits(rn);
  endfunction

  function automatic bit exp_stall();
    bit w;
    if (!iss_valid) return 1'b0;
    w = iss_we && (iss_wn != 0) && mbusy[iss_wn] && !(we && wn == iss_wn);
    return (use_a && !exp_rdy(rna)) || (use_b && !exp_rdy(rnb)) || w;
  endfunction

  function automatic int unsigned exp_cnt();
    int unsigned n = 0;
    for (int i = 1; i < 32; i++) if (mbusy[i]) n++;
    return n;
  endfunction

  // Spec-level update at a clock edge: writeback clears, accepted issue sets after
  function automatic void model_edge();
    bit ok;
    ok = iss_valid && !exp_stall();
    if (we && wn != 0) begin
      mreg[wn]  = d;
      mbusy[wn] = 1'b0;
    end
    if (ok && iss_we && iss_wn != 0) mbusy[iss_wn] = 1'b1;
  endfunction

  task automatic settle_check();
    #1;
    if (rst) model_reset();
    check("qa", qa, exp_q(rna));
    check("qb", qb, exp_q(rnb));
    check("qa_rdy", qa_rdy, exp_rdy(rna));
    check("qb_rdy", qb_rdy, exp_rdy(rnb));
    check("stall", stall, exp_stall());
    check("busy_cnt", busy_cnt, exp_cnt());
  endtask

  task automatic tick();
    settle_check();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    iss_valid = 0; iss_we = 0; iss_wn = 0; use_a = 0; use_b = 0;
    we = 0; wn = 0; d = '0; rna = 0; rnb = 0;
  endtask

  logic [5:0] cnt_snap;

  initial begin
    rst = 0;
    idle();
    model_reset();
    #2 rst = 1;
    @(negedge clk);
    // Reset state, with an instruction trying to consume operands
    iss_valid = 1; use_a = 1; use_b = 1; rna = 5; rnb = 17; iss_we = 1; iss_wn = 3;
    settle_check();
    check("rst_qa", qa, 32'h0);
    check("rst_qa_rdy", qa_rdy, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_cnt", busy_cnt, 6'd0);
    idle();
    tick();
    rst = 0;
    @(negedge clk);

    // jal-style write to r31, then a write to r0
    we = 1; wn = 31; d = 32'h0040_0008;
    tick();
    idle(); rna = 31;
    settle_check();
    check("jal_qa", qa, 32'h0040_0008);
    we = 1; wn = 0; d = 32'hFFFF_FFFF;
    tick();
    idle(); rna = 0;
    settle_check();
    check("r0_qa", qa, 32'h0);

    // RAW on r8 resolved by writeback
    iss_valid = 1; iss_we = 1; iss_wn = 8;
    tick();
    idle(); iss_valid = 1; rna = 8; use_a = 1;
    settle_check();
    check("raw_rdy", qa_rdy, 1'b0);
    check("raw_stall", stall, 1'b1);
    check("raw_cnt", busy_cnt, 6'd1);
    we = 1; wn = 8; d = 32'h1234;
    settle_check();
`ifdef REGFILE_BYPASS_EN
    check("byp_qa", qa, 32'h1234);
    check("byp_stall", stall, 1'b0);
`else
    check("nobyp_stall", stall, 1'b1);
`endif
    tick();
    we = 0; wn = 0; d = '0;
    settle_check();
    check("after_wb_qa", qa, 32'h1234);
    check("after_wb_stall", stall, 1'b0);
    check("after_wb_cnt", busy_cnt, 6'd0);
    idle();
    tick();

    // WAW on r9, released by a same-cycle writeback that keeps it busy
    iss_valid = 1; iss_we = 1; iss_wn = 9;
    tick();
    settle_check();
    check("waw_stall", stall, 1'b1);
    we = 1; wn = 9; d = 32'h99;
    settle_check();
    check("waw_clear_stall", stall, 1'b0);
    cnt_snap = busy_cnt;
    tick();
    idle(); rna = 9;
    settle_check();
    check("waw_still_busy", qa_rdy, 1'b0);
    check("waw_cnt_same", busy_cnt, cnt_snap);
    check("waw_cnt", busy_cnt, 6'd1);

    // Port b dependency gated by use_b and iss_valid
    iss_valid = 1; iss_we = 1; iss_wn = 10;
    tick();
    idle(); iss_valid = 1; rnb = 10; use_b = 0;
    settle_check();
    check("pb_unused", stall, 1'b0);
    use_b = 1;
    settle_check();
    check("pb_used", stall, 1'b1);
    iss_valid = 0;
    settle_check();
    check("pb_novalid", stall, 1'b0);
    idle();
    tick();

    // Asynchronous reset with three pending marks
    iss_valid = 1; iss_we = 1; iss_wn = 5;
    tick();
    idle();
    settle_check();
    check("pre_rst_cnt", busy_cnt, 6'd3);
    rst = 1; rna = 5; use_a = 1; iss_valid = 1;
    settle_check();
    check("mid_rst_cnt", busy_cnt, 6'd0);
    check("mid_rst_qa", qa, 32'h0);
    check("mid_rst_rdy", qa_rdy, 1'b1);
    check("mid_rst_stall", stall, 1'b0);
    tick();
    rst = 0; idle();
    we = 1; wn = 9; d = 32'hABCD;
    tick();
    idle(); rna = 9;
    settle_check();
    check("post_rst_wb_qa", qa, 32'hABCD);
    check("post_rst_wb_cnt", busy_cnt, 6'd0);

    // Fill the whole scoreboard, then drain it
    for (int i = 1; i < 32; i++) begin
      idle(); iss_valid = 1; iss_we = 1; iss_wn = 5'(i);
      tick();
    end
    idle();
    settle_check();
    check("full_cnt", busy_cnt, 6'd31);
    for (int i = 1; i < 32; i++) begin
      idle(); we = 1; wn = 5'(i); d = 32'(i * 3);
      tick();
    end
    idle();
    settle_check();
    check("drain_cnt", busy_cnt, 6'd0);
    we = 1; wn = 3; d = 32'h5;
    tick();
    idle();
    settle_check();
    check("extra_wb_cnt", busy_cnt, 6'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      rna       = 5'($urandom_range(0, 7));
      rnb       = 5'($urandom_range(0, 7));
      use_a     = 1'($urandom_range(0, 1));
      use_b     = 1'($urandom_range(0, 1));
      iss_valid = 1'($urandom_range(0, 1));
      iss_we    = 1'($urandom_range(0, 1));
      iss_wn    = 5'($urandom_range(0, 7));
      we        = ($urandom_range(0, 2) == 0);
      wn        = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      d         = $urandom;
      tick();
    end
    rst = 0;
    idle();
    settle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
